// File: rtl/shift_seq9900.sv
// Shift sequencer for TMS9900 SLA/SRA/SRC/SRL: drives the ALU one bit per clock.
// SHIFT9900_STATUS_EN adds a FLAGS state that captures ST0..ST2 from an ALU load2.
//
// state   | meaning
// S_IDLE  | waiting for start; ALU inputs parked
// S_SHIFT | one single-bit shift per clock, counter running down
// S_FLAGS | load2 of final word, capture lgt/agt/eq (status build only)
module shift_seq9900 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  shift_op,
  input  logic [3:0]  count_field,
  input  logic [3:0]  r0_low,
  input  logic [15:0] operand,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        st_lgt,
  output logic        st_agt,
  output logic        st_eq,
  output logic        st_c,
  output logic        st_ov,
  output logic [3:0]  alu_ope,
  output logic [15:0] alu_arg1,
  output logic [15:0] alu_arg2,
  output logic        alu_compare,
  input  logic [15:0] alu_result,
  input  logic        alu_flag_carry,
  input  logic        alu_flag_overflow,
  input  logic        alu_logical_gt,
  input  logic        alu_arithmetic_gt,
  input  logic        alu_flag_zero
);

`ifdef SHIFT9900_STATUS_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FLAGS} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t      state, state_nxt;
  logic [15:0] sreg;
  logic [4:0]  cnt;
  logic [4:0]  n_start;
  logic [1:0]  op_q;

  // A zero C field defers to R0; a zero R0 means a full 16-bit shift.
  assign n_start = (count_field != 4'd0) ? {1'b0, count_field} :
                   (r0_low != 4'd0)      ? {1'b0, r0_low}      : 5'd16;

  assign busy        = (state != S_IDLE);
  assign result      = sreg;
  assign alu_arg1    = 16'h0000;
  assign alu_arg2    = sreg;
  assign alu_compare = 1'b0;

  always_comb begin
    state_nxt = state;
    alu_ope   = 4'h0;
    case (state)
      S_IDLE: if (start) state_nxt = S_SHIFT;
      S_SHIFT: begin
        alu_ope = {2'b11, op_q};
`ifdef SHIFT9900_STATUS_EN
        if (cnt == 5'd1) state_nxt = S_FLAGS;
`else
        if (cnt == 5'd1) state_nxt = S_IDLE;
`endif
      end
`ifdef SHIFT9900_STATUS_EN
      S_FLAGS: begin
        alu_ope   = 4'h1;
        state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef SHIFT9900_STATUS_EN
  logic lgt_q, agt_q, eq_q;
  assign st_lgt = lgt_q;
  assign st_agt = agt_q;
  assign st_eq  = eq_q;
`else
  // ST0..ST2 come from elsewhere in the CPU when FLAGS is compiled out.
  logic unused_status;
  assign unused_status = ^{alu_logical_gt, alu_arithmetic_gt, alu_flag_zero};
  assign st_lgt = 1'b0;
  assign st_agt = 1'b0;
  assign st_eq  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      sreg  <= 16'h0000;
      cnt   <= 5'd0;
      op_q  <= 2'b00;
      done  <= 1'b0;
      st_c  <= 1'b0;
      st_ov <= 1'b0;
`ifdef SHIFT9900_STATUS_EN
      lgt_q <= 1'b0;
      agt_q <= 1'b0;
      eq_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          sreg  <= operand;
          cnt   <= n_start;
          op_q  <= shift_op;
          st_c  <= 1'b0;
          st_ov <= 1'b0;
        end
        S_SHIFT: begin
          sreg  <= alu_result;
          st_c  <= alu_flag_carry;
          // Overflow is sticky across steps and only meaningful for SLA.
          st_ov <= (op_q == 2'b00) & (st_ov | alu_flag_overflow);
          cnt   <= cnt - 5'd1;
`ifndef SHIFT9900_STATUS_EN
          if (cnt == 5'd1) done <= 1'b1;
`endif
        end
`ifdef SHIFT9900_STATUS_EN
        S_FLAGS: begin
          lgt_q <= alu_logical_gt;
          agt_q <= alu_arithmetic_gt;
          eq_q  <= alu_flag_zero;
          done  <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
